// File: rtl/sensor_pkg.sv
// sensor_pkg: sensor count, reading width and scanner FSM encoding shared with the height logic
package sensor_pkg;
    localparam int NUM_SENSORS = 4;
    localparam int SENSOR_W    = 8;
    localparam int IDX_W       = $clog2(NUM_SENSORS);
    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
endpackage

// File: rtl/hs_timeout.sv
// hs_timeout: clearable saturating up-counter flagging when LIMIT cycles have elapsed
module hs_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    assign expired = cnt == W'(LIMIT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/sensor_scanner.sv
// sensor_scanner: polls four sensors over a four-phase req/ack bus and publishes atomic snapshots; SENSOR_SCANNER_TIMEOUT_EN adds per-phase timeouts
module sensor_scanner
    import sensor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [IDX_W-1:0]    sens_sel,
    output logic                sens_req,
    input  logic                sens_ack,
    input  logic [SENSOR_W-1:0] sens_data,
    output logic [SENSOR_W-1:0] sensor1,
    output logic [SENSOR_W-1:0] sensor2,
    output logic [SENSOR_W-1:0] sensor3,
    output logic [SENSOR_W-1:0] sensor4,
    output logic                snap_valid,
    output logic                busy,
    output logic [NUM_SENSORS-1:0] fault
);
    state_t state, state_nx;
    logic [IDX_W-1:0]       idx;
    logic [SENSOR_W-1:0]    shadow [NUM_SENSORS];
    logic [SENSOR_W-1:0]    snap   [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] shadow_flt, flt_nx;
    logic to_exp, req_go, rel_go, last;
`ifdef SENSOR_SCANNER_TIMEOUT_EN
    hs_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_nx != state),
        .expired (to_exp)
    );
`else
    assign to_exp = 1'b0;
`endif
    assign req_go   = state == REQ && (sens_ack || to_exp);
    assign rel_go   = state == RELEASE && (!sens_ack || to_exp);
    assign last     = idx == IDX_W'(NUM_SENSORS - 1);
    assign sens_req = state == REQ;
    assign busy     = state != IDLE;
    assign sens_sel = idx;
    assign {sensor4, sensor3, sensor2, sensor1} = {snap[3], snap[2], snap[1], snap[0]};
    always_comb begin
        state_nx = state == IDLE ? (start && !sens_ack ? REQ : IDLE)
                 : req_go        ? RELEASE
                 : rel_go        ? (last ? IDLE : REQ)
                 : state;
        flt_nx = shadow_flt;
        if (req_go)
            flt_nx[idx] = !sens_ack;
        if (rel_go && sens_ack)
            flt_nx[idx] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            shadow     <= '{default: '0};
            snap       <= '{default: '0};
            shadow_flt <= '0;
            fault      <= '0;
            snap_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            shadow_flt <= flt_nx;
            snap_valid <= rel_go && last;
            if (state == IDLE && state_nx == REQ)
                idx <= '0;
            else if (rel_go && !last)
                idx <= idx + 1'b1;
            if (req_go)
                shadow[idx] <= sens_ack ? sens_data : '0;
            if (rel_go && last) begin
                snap  <= shadow;
                fault <= flt_nx;
            end
        end
endmodule

// File: tb/tb_sensor_scanner.sv
// tb_sensor_scanner: randomized scans against a handshake-level model of the scanner
module tb_sensor_scanner;
    logic       clk, rst_n, start, sens_req, sens_ack, snap_valid, busy;
    logic [1:0] sens_sel;
    logic [7:0] sens_data, sensor1, sensor2, sensor3, sensor4;
    logic [3:0] fault;
    int n_cmp = 0, n_bad = 0;
    int resp_lat = 1, skip = 4, hold = 4, cnt = 0;
    bit stuck = 0;
    logic [7:0] resp_vals [4];
    logic [7:0] sel_seq = '0;
    logic [31:0] snap_model = '0;
    logic [3:0]  fault_model = '0;

    sensor_scanner #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sens_sel(sens_sel), .sens_req(sens_req),
        .sens_ack(sens_ack), .sens_data(sens_data), .sensor1(sensor1), .sensor2(sensor2),
        .sensor3(sensor3), .sensor4(sensor4), .snap_valid(snap_valid), .busy(busy), .fault(fault)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Responder: answers each phase resp_lat cycles after seeing the request change
    initial begin
        sens_ack = 0;
        sens_data = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || stuck) begin
                sens_ack = stuck;
                cnt = 0;
            end else if (sens_req && !sens_ack && 32'(sens_sel) != skip) begin
                if (cnt >= resp_lat) begin
                    sens_ack = 1;
                    sens_data = resp_vals[sens_sel];
                    sel_seq = {sel_seq[5:0], sens_sel};
                    cnt = 0;
                end else cnt++;
            end else if (!sens_req && sens_ack && !(busy && 32'(sens_sel) == hold)) begin
                if (cnt >= resp_lat) begin
                    sens_ack = 0;
                    sens_data = 8'($urandom);
                    cnt = 0;
                end else cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scan(input logic [31:0] vals, input int lat, input int skip_i, input int hold_i, input bit mid);
        logic [31:0] exp_v;
        logic [3:0]  exp_f;
        logic [7:0]  exp_seq, mask;
        int k;
        bit held;
        exp_seq = '0;
        mask = skip_i < 4 ? 8'h3F : 8'hFF;
        for (int i = 0; i < 4; i++) begin
            resp_vals[i] = vals[8*i +: 8];
            exp_v[8*i +: 8] = i == skip_i ? 8'h00 : vals[8*i +: 8];
            exp_f[i] = i == skip_i || i == hold_i;
            if (i != skip_i) exp_seq = {exp_seq[5:0], 2'(i)};
        end
        resp_lat = lat;
        skip = skip_i;
        hold = hold_i;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        chk("req_after_start", {busy, sens_req}, 2'b11);
        k = 0;
        held = 1;
        while (!snap_valid && k < 400) begin
            held &= {sensor4, sensor3, sensor2, sensor1} === snap_model && fault === fault_model;
            @(negedge clk);
            k++;
            start = mid && k == 3;
        end
        start = 0;
        chk("snap_valid_seen", snap_valid, 1);
        chk("held_until_snap", held, 1);
        if (skip_i == 4 && hold_i == 4) chk("scan_edges", k, 8 * (lat + 1));
        chk("snapshot", {sensor4, sensor3, sensor2, sensor1}, exp_v);
        chk("fault", fault, exp_f);
        chk("sel_order", sel_seq & mask, exp_seq);
        snap_model = exp_v;
        fault_model = exp_f;
        @(negedge clk);
        chk("snap_valid_pulse", snap_valid, 0);
        repeat (3) @(negedge clk);
        chk("idle_after_scan", busy, 0);
    endtask

    initial begin
        bit found;
        rst_n = 0;
        start = 1;
        repeat (4) @(negedge clk);
        chk("reset_outputs", {sens_req, sens_sel, snap_valid, busy, fault}, 0);
        chk("reset_snapshot", {sensor4, sensor3, sensor2, sensor1}, 0);
        start = 0;
        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("no_scan_after_reset", busy, 0);

        scan(32'h281E140A, 1, 4, 4, 0);
        scan(32'h50463C32, 1, 4, 4, 1);
        repeat (6) scan($urandom, int'($urandom_range(0, 3)), 4, 4, 1'($urandom));

        stuck = 1;
        repeat (2) @(negedge clk);
        start = 1;
        @(negedge clk) start = 0;
        repeat (3) @(negedge clk);
        chk("start_with_ack_ignored", busy, 0);
        stuck = 0;
        repeat (4) @(negedge clk);

        resp_lat = 1;
        for (int i = 0; i < 4; i++) resp_vals[i] = 8'($urandom);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            found = sens_req && sens_sel == 2'd2;
            if (!found) @(negedge clk);
        end
        chk("reached_sensor3_req", found, 1);
        rst_n = 0;
        #1;
        chk("async_reset_ctrl", {sens_req, busy, snap_valid, fault}, 0);
        chk("async_reset_snapshot", {sensor4, sensor3, sensor2, sensor1}, 0);
        snap_model = '0;
        fault_model = '0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk("no_resume_after_reset", {busy, sens_req}, 0);
        scan($urandom, 2, 4, 4, 0);

`ifdef SENSOR_SCANNER_TIMEOUT_EN
        scan($urandom, 1, 1, 4, 0);
        scan($urandom, 1, 4, 3, 0);
        scan($urandom, 0, 4, 4, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
